vga_fb_reader: RTL and testbench

- Pixel source stage between vga_sync and the VGA pins/graphics mux. Consumes vga_sync timing (pixel_x, pixel_y, display_on, h_sync, v_sync).
- Reads a 160x120 palette-indexed framebuffer, upscaled 4x to 640x480. The framebuffer is written by robot-side logic.
- Outputs 4-bit R/G/B with sync delayed to match a fixed 3-cycle pipeline.

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fb_ram.sv | 25 ++
 rtl/vga_fb_reader.sv | 129 ++++++++++++
 tb/tb_vga_fb_reader.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants, colour type and default palette for the VGA framebuffer reader.
package vga_pkg;

    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;
    localparam int FB_W     = 160;
    localparam int FB_H     = 120;
    localparam int FB_DEPTH = FB_W * FB_H;
    localparam int FB_AW    = 15;
    localparam int PIPE_LAT = 3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb12;

    // Reset palette: entry i is the grey level {i,i,i}.
    function automatic rgb12 default_pal(input logic [3:0] idx);
        rgb12 c;
        c.r = idx;
        c.g = idx;
        c.b = idx;
        return c;
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// Simple dual-port framebuffer RAM: one write port, one registered read-first read port.
module vga_fb_ram #(
    parameter int DEPTH = 19200,
    parameter int AW    = 15,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];

    // Both updates are non-blocking, so a same-address read returns the old word.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_fb_reader.sv
// Three-stage pixel source: screen coordinate -> framebuffer address -> palette index -> RGB,
// with the sync signals delayed by the same three cycles.
module vga_fb_reader #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int IDX_W      = 4
) (
    input  logic             clock_25,
    input  logic             reset,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             display_on,
    input  logic             h_sync_in,
    input  logic             v_sync_in,
    input  logic             wr_en,
    input  logic [14:0]      wr_addr,
    input  logic [IDX_W-1:0] wr_data,
    input  logic             pal_we,
    input  logic [IDX_W-1:0] pal_idx,
    input  logic [11:0]      pal_rgb,
    output logic [3:0]       R,
    output logic [3:0]       G,
    output logic [3:0]       B,
    output logic             h_sync,
    output logic             v_sync,
    output logic             frame_start
);
    import vga_pkg::*;

    localparam int DEPTH = FB_W * FB_H;
    localparam int PAL_N = 1 << IDX_W;

    logic [FB_AW-1:0] fb_x, fb_y, addr_calc;
    logic             vis_calc, org_calc, wr_ok;

    logic [FB_AW-1:0] addr_reg;
    logic             vis_s1_reg, org_s1_reg;
    logic             vis_s2_reg, org_s2_reg;
    logic [IDX_W-1:0] rd_idx;
    rgb12             rgb_reg;
    logic             frame_start_reg;
    logic [PIPE_LAT-1:0] h_pipe_reg, v_pipe_reg;
    rgb12             pal_reg [PAL_N];

    // y*160 + x built from shifts; y*128 + y*32.
    assign fb_x      = FB_AW'(pixel_x >> SCALE_LOG2);
    assign fb_y      = FB_AW'(pixel_y >> SCALE_LOG2);
    assign addr_calc = (fb_y << 7) + (fb_y << 5) + fb_x;
    assign vis_calc  = display_on && (pixel_x < 10'(H_ACTIVE)) && (pixel_y < 10'(V_ACTIVE));
    assign org_calc  = vis_calc && (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign wr_ok     = wr_en && (wr_addr < FB_AW'(DEPTH));

    // S1: address and visibility; invisible pixels read address 0 so the RAM index stays in range.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            addr_reg   <= '0;
            vis_s1_reg <= 1'b0;
            org_s1_reg <= 1'b0;
        end else begin
            addr_reg   <= vis_calc ? addr_calc : '0;
            vis_s1_reg <= vis_calc;
            org_s1_reg <= org_calc;
        end
    end

    vga_fb_ram #(
        .DEPTH (DEPTH),
        .AW    (FB_AW),
        .DW    (IDX_W)
    ) u_ram (
        .clk     (clock_25),
        .we      (wr_ok),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (addr_reg),
        .rd_data (rd_idx)
    );

    // S2: qualifiers travel alongside the RAM read.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            vis_s2_reg <= 1'b0;
            org_s2_reg <= 1'b0;
        end else begin
            vis_s2_reg <= vis_s1_reg;
            org_s2_reg <= org_s1_reg;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            for (int i = 0; i < PAL_N; i++) begin
                pal_reg[i] <= default_pal(4'(i));
            end
        end else if (pal_we) begin
            pal_reg[pal_idx] <= rgb12'(pal_rgb);
        end
    end

    // S3: palette lookup sees the pre-write palette when written on the same edge.
    always_ff @(posedge clock_25) begin
        if (reset) begin
            rgb_reg         <= '0;
            frame_start_reg <= 1'b0;
        end else begin
            rgb_reg         <= vis_s2_reg ? pal_reg[rd_idx] : '0;
            frame_start_reg <= org_s2_reg;
        end
    end

    always_ff @(posedge clock_25) begin
        if (reset) begin
            h_pipe_reg <= '1;
            v_pipe_reg <= '1;
        end else begin
            h_pipe_reg <= {h_pipe_reg[PIPE_LAT-2:0], h_sync_in};
            v_pipe_reg <= {v_pipe_reg[PIPE_LAT-2:0], v_sync_in};
        end
    end

    assign R           = rgb_reg.r;
    assign G           = rgb_reg.g;
    assign B           = rgb_reg.b;
    assign h_sync      = h_pipe_reg[PIPE_LAT-1];
    assign v_sync      = v_pipe_reg[PIPE_LAT-1];
    assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_fb_reader.sv
// Directed bench for vga_fb_reader: expected pixels are queued when driven and checked three edges later.
module tb_vga_fb_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  pixel_x, pixel_y;
    logic        display_on, h_sync_in, v_sync_in;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [3:0]  wr_data;
    logic        pal_we;
    logic [3:0]  pal_idx;
    logic [11:0] pal_rgb;
    logic [3:0]  R, G, B;
    logic        h_sync, v_sync, frame_start;

    always #20 clk = ~clk;

    vga_fb_reader dut (
        .clock_25    (clk),
        .reset       (reset),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .display_on  (display_on),
        .h_sync_in   (h_sync_in),
        .v_sync_in   (v_sync_in),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .pal_we      (pal_we),
        .pal_idx     (pal_idx),
        .pal_rgb     (pal_rgb),
        .R           (R),
        .G           (G),
        .B           (B),
        .h_sync      (h_sync),
        .v_sync      (v_sync),
        .frame_start (frame_start)
    );

    typedef struct {
        logic        vis;
        logic        org;
        logic        hs;
        logic        vs;
        int          addr;
        logic [3:0]  idx;
        logic [11:0] rgb;
    } ent_t;

    ent_t        q[$];
    logic [3:0]  fb_m [0:19199];
    logic [11:0] pal_m [0:15];
    int          n_checks = 0;
    int          n_pass   = 0;
    string       cur_tag  = "init";

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        n_checks++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, got, exp);
    endtask

    task automatic pix(input int x, input int y, input logic d);
        pixel_x    = 10'(x);
        pixel_y    = 10'(y);
        display_on = d;
    endtask

    task automatic clr();
        wr_en  = 1'b0;
        pal_we = 1'b0;
    endtask

    // One clock: resolve queued entries at the stage they reach this edge, apply writes, then check.
    task automatic step();
        ent_t e, o, f;
        logic [3:0] i4;
        f.vis = 1'b0; f.org = 1'b0; f.hs = 1'b1; f.vs = 1'b1;
        f.addr = 0; f.idx = 4'h0; f.rgb = 12'h000;
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                i4 = 4'(i);
                pal_m[i] = {i4, i4, i4};
            end
            q.delete();
            @(posedge clk); #1;
            $display("%s: reset rgb=%h hs=%b vs=%b fs=%b", cur_tag, {R, G, B}, h_sync, v_sync, frame_start);
            check({cur_tag, "_rgb"}, {R, G, B}, 12'h000);
            check({cur_tag, "_sync"}, {10'b0, h_sync, v_sync}, 12'h003);
            check({cur_tag, "_fs"}, {11'b0, frame_start}, 12'h000);
            q.push_back(f);
            q.push_back(f);
        end else begin
            e = q[1];
            if (e.vis) e.idx = fb_m[e.addr];
            q[1] = e;
            e = q[0];
            e.rgb = e.vis ? pal_m[e.idx] : 12'h000;
            q[0] = e;
            e.vis  = display_on && (pixel_x < 640) && (pixel_y < 480);
            e.org  = e.vis && (pixel_x == 0) && (pixel_y == 0);
            e.hs   = h_sync_in;
            e.vs   = v_sync_in;
            e.addr = e.vis ? (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4 : 0;
            e.idx  = 4'h0;
            e.rgb  = 12'h000;
            q.push_back(e);
            if (wr_en && wr_addr < 15'd19200) fb_m[wr_addr] = wr_data;
            if (pal_we) pal_m[pal_idx] = pal_rgb;
            @(posedge clk); #1;
            o = q.pop_front();
            $display("%s: rgb=%h exp=%h hs/vs=%b%b exp=%b%b fs=%b exp=%b", cur_tag, {R, G, B}, o.rgb,
                     h_sync, v_sync, o.hs, o.vs, frame_start, o.org);
            check({cur_tag, "_rgb"}, {R, G, B}, o.rgb);
            check({cur_tag, "_sync"}, {10'b0, h_sync, v_sync}, {10'b0, o.hs, o.vs});
            check({cur_tag, "_fs"}, {11'b0, frame_start}, {11'b0, o.org});
        end
    endtask

    initial begin
        reset = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
        wr_addr = '0; wr_data = '0; pal_idx = '0; pal_rgb = '0;
        clr();
        pix(0, 0, 1'b0);

        cur_tag = "reset0"; h_sync_in = 1'b0; v_sync_in = 1'b1; step();
        cur_tag = "reset1"; h_sync_in = 1'b1; v_sync_in = 1'b0; step();
        reset = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;

        cur_tag = "wr_a0_3"; wr_en = 1'b1; wr_addr = 15'd0; wr_data = 4'd3; step(); clr();
        cur_tag = "gray3"; pix(0, 0, 1'b1); step();
        cur_tag = "idle"; pix(0, 0, 1'b0); step(); step();

        cur_tag = "wr_a1_9"; wr_en = 1'b1; wr_addr = 15'd1; wr_data = 4'd9; step();
        cur_tag = "wr_a0_5"; wr_addr = 15'd0; wr_data = 4'd5; step(); clr();
        cur_tag = "pal5"; pal_we = 1'b1; pal_idx = 4'd5; pal_rgb = 12'hF00; step(); clr();
        for (int x = 0; x <= 4; x++) begin
            cur_tag = $sformatf("sweep_x%0d", x);
            pix(x, 0, 1'b1);
            step();
        end
        cur_tag = "idle"; pix(0, 0, 1'b0); step();

        cur_tag = "wr_last"; wr_en = 1'b1; wr_addr = 15'd19199; wr_data = 4'd2;
        pal_we = 1'b1; pal_idx = 4'd2; pal_rgb = 12'h0A5; step(); clr();
        cur_tag = "corner"; pix(639, 479, 1'b1); step();
        cur_tag = "wr_oob"; pix(0, 0, 1'b0); wr_en = 1'b1; wr_addr = 15'd19200; wr_data = 4'hE; step(); clr();
        cur_tag = "post_oob_a0"; pix(0, 0, 1'b1); step();
        cur_tag = "post_oob_last"; pix(639, 479, 1'b1); step();

        cur_tag = "disp_off"; pix(0, 0, 1'b0); step();
        cur_tag = "x700"; pix(700, 0, 1'b1); step();
        cur_tag = "x640"; pix(640, 0, 1'b1); step();
        cur_tag = "y480"; pix(0, 480, 1'b1); step();
        for (int i = 0; i < 6; i++) begin
            cur_tag = $sformatf("sync_%0d", i);
            h_sync_in = 1'($urandom_range(0, 1));
            v_sync_in = 1'($urandom_range(0, 1));
            pix(4 * (i % 2), 0, 1'(i % 3 != 0));
            step();
        end
        h_sync_in = 1'b1; v_sync_in = 1'b1;

        cur_tag = "coll_rd"; pix(0, 0, 1'b1); step();
        cur_tag = "coll_wr"; pix(4, 0, 1'b1); wr_en = 1'b1; wr_addr = 15'd0; wr_data = 4'd7; step(); clr();
        cur_tag = "coll_new"; pix(0, 0, 1'b1); step();
        cur_tag = "palc_rd"; pix(4, 0, 1'b1); step();
        cur_tag = "palc_mid"; pix(0, 0, 1'b0); step();
        cur_tag = "palc_wr"; pal_we = 1'b1; pal_idx = 4'd9; pal_rgb = 12'h123; step(); clr();
        cur_tag = "palc_new"; pix(4, 0, 1'b1); step();

        cur_tag = "wr_mid"; pix(0, 0, 1'b0); wr_en = 1'b1; wr_addr = 15'd1675; wr_data = 4'd6; step(); clr();
        pix(300, 40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cur_tag = $sformatf("line_%0d", i);
            step();
        end
        cur_tag = "mid_reset"; reset = 1'b1; step(); reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_tag = $sformatf("after_rst_%0d", i);
            step();
        end
        cur_tag = "drain"; pix(0, 0, 1'b0);
        for (int i = 0; i < 3; i++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
